serial_pair_serializer_msb_first: RTL
=====================================

# serial_pair_serializer_msb_first

Front-end stage feeding `serial_comparator_most_significant_first_using_fsm`. It accepts a pair of parallel words over a valid/ready handshake and clears the comparator. It then shifts both words out MSB-first, one bit pair per clock, and captures the comparator's final verdict into a registered result with a one-cycle valid pulse. One pair is in flight at a time.

## Interface
- `WIDTH`, 8, bits per word; legal range ≥ 1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream has a word pair.
- `in_a`  in  WIDTH  operand A, parallel.
- `in_b`  in  WIDTH  operand B, parallel.
- `in_ready`  out  1  block can accept a pair this cycle.
- `ser_a`  out  1  serial A bit to comparator `a`.
- `ser_b`  out  1  serial B bit to comparator `b`.
- `ser_valid`  out  1  `ser_a`/`ser_b` carry a real bit.
- `ser_last`  out  1  current bit is the LSB.
- `cmp_clear`  out  1  drives comparator `rst`.
- `cmp_less`, `cmp_eq`, `cmp_greater`  in  1 each  comparator outputs.
- `res_valid`  out  1  one-cycle pulse; result fields are new.
- `res_less`, `res_eq`, `res_greater`  out  1 each  captured verdict, held until the next `res_valid`.

## Operation
- FSM has three states: `IDLE`, `SHIFT`, `RESULT`. Reset state is `IDLE`.
- **`IDLE`**
  - `in_ready=1` and `cmp_clear=1`.
  - On `in_valid & in_ready`: load `in_a`/`in_b` into shift registers, load bit counter with WIDTH-1, go to `SHIFT`.
- **`SHIFT`**
  - `ser_valid=1`; `ser_a`/`ser_b` = MSB of their shift registers.
  - Each cycle: shift both registers left by 1 and decrement the counter.
  - `ser_last=1` when counter==0; on that cycle go to `RESULT`.
- **`RESULT`**
  - Comparator outputs now reflect all WIDTH bits.
  - Register `cmp_less/eq/greater` into `res_*`, set `res_valid` (registered, visible next cycle), go to `IDLE`.
- Outside `SHIFT`, `ser_a=ser_b=0`, so the comparator sees equal bits and holds its state.
- `in_valid` is ignored outside `IDLE`. `in_a`/`in_b` are sampled only at acceptance and need not be held afterwards.
- No backpressure on results: `res_valid` is a pulse, and the consumer must take it.
- Counter width is max(1, $clog2(WIDTH)).
- **WIDTH=1:** `SHIFT` lasts exactly one cycle, with `ser_last` high on it.

## Timing
- Pair accepted at edge 0:
  - Bit k (MSB=k=0) is on `ser_*` in cycle k+1, for k=0..WIDTH-1.
  - `RESULT` in cycle WIDTH+1.
  - `res_valid` high and `in_ready` high again in cycle WIDTH+2.
- Throughput: one pair per WIDTH+2 cycles. Back-to-back acceptance is legal in the cycle `res_valid` pulses.
- `cmp_clear` is high throughout `IDLE` and is a registered-state decode. It deasserts in the same cycle the MSB appears, so the comparator starts from `equal`.
- **Reset values** (async, effective immediately):
  - state `IDLE`; `in_ready=1`, `cmp_clear=1`.
  - `ser_valid=0`, `ser_last=0`, `ser_a=0`, `ser_b=0`.
  - `res_valid=0`, `res_less=0`, `res_eq=1`, `res_greater=0`; shift registers and counter 0.
- While `rst` is high, a handshake has no effect even though `in_ready` reads 1.
- **Reset mid-`SHIFT` or mid-`RESULT`:**
  - The pair is discarded and no `res_valid` is produced.
  - `cmp_clear` asserts asynchronously via state.
- Result fields are one-hot whenever `res_valid=1`.

## Structure
- Shared package `serial_cmp_pkg`:
  - `typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_RESULT} ser_state_t;`
  - reset constant for the result triple (`3'b010` = eq).
- One natural sub-module: `msb_first_shift_reg #(WIDTH)`, a parallel load, shift-left, MSB-out register. Instantiate it twice, for A and B.
- FSM, counter and result capture stay in the top module.

## Test plan
- **WIDTH=4, basic less:** in_a=4'b0101, in_b=4'b0110, comparator attached.
  - `ser_a`=0,1,0,1 and `ser_b`=0,1,1,0 in cycles 1-4; `ser_last` in cycle 4.
  - `res_valid` in cycle 6 with less=1.
- **Greater and equal, back-to-back:** pairs (9,3) then (7,7), with `in_valid` held high.
  - Second accept occurs in the `res_valid` cycle of the first.
  - Results: greater, then eq.
- **WIDTH=1:** pairs (1,0) and (0,1).
  - `ser_valid` and `ser_last` are high together for 1 cycle.
  - Results greater, then less; latency 3 cycles.
- **Reset mid-SHIFT:** assert `rst` in cycle 2 of a WIDTH=4 transfer.
  - Outputs take reset values immediately; no `res_valid`.
  - The next pair (2,2) yields eq with correct timing.
- **Handshake robustness:** toggle `in_valid` and change `in_a`/`in_b` during `SHIFT`.
  - Serial stream matches the values captured at acceptance.
  - `in_ready`=0 for the WIDTH+1 cycles after acceptance.
- **Exhaustive WIDTH=3:** all 64 pairs.
  - Each `res_*` matches the integer comparison.
  - Result is one-hot and held stable between pulses.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_cmp_pkg
//  Description : Shared types and constants for the MSB-first serial pair
//                serializer feeding a serial magnitude comparator.
//                - ser_state_t : serializer FSM state encoding
//                - C_RES_RESET : reset value of the {less, eq, greater} triple
//                - cnt_width() : bit counter width for a given word width
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_RESULT = 2'd2
  } ser_state_t;

  // Result triple is ordered {less, eq, greater}; reset reads as "equal".
  localparam logic [2:0] C_RES_RESET = 3'b010;

  // The counter must hold WIDTH-1; a one-bit word still needs a 1-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/msb_first_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : msb_first_shift_reg
//  Description : Parallel-load, shift-left register presenting its MSB as the
//                serial output. Load has priority over shift.
//  Ports       : clk     in  clock, rising edge
//                rst     in  asynchronous active-high reset (clears register)
//                load_i  in  capture data_i
//                shift_i in  shift left by one, zero fill
//                data_i  in  parallel word [WIDTH-1:0]
//                msb_o   out current MSB of the register
//  Revision    : 1.0 - initial release
// ============================================================================
module msb_first_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = data_i;
    end else if (shift_i) begin
      data_d = data_q << 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign msb_o = data_q[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/serial_pair_serializer_msb_first.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pair_serializer_msb_first
//  Description : Accepts a pair of parallel words over valid/ready, clears the
//                downstream serial comparator, shifts both words out MSB-first
//                one bit pair per clock, then captures the comparator verdict
//                into a registered result with a one-cycle valid pulse.
//  Ports       : clk, rst                      clock / async active-high reset
//                in_valid_i, in_a_i, in_b_i    upstream word pair
//                in_ready_o                    pair can be accepted (IDLE)
//                ser_a_o, ser_b_o              serial bits to comparator
//                ser_valid_o, ser_last_o       bit qualifier / LSB marker
//                cmp_clear_o                   comparator reset
//                cmp_less_i/eq_i/greater_i     comparator verdict
//                res_valid_o                   one-cycle result pulse
//                res_less_o/eq_o/greater_o     captured verdict (held)
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_pair_serializer_msb_first
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  output logic             in_ready_o,
  output logic             ser_a_o,
  output logic             ser_b_o,
  output logic             ser_valid_o,
  output logic             ser_last_o,
  output logic             cmp_clear_o,
  input  logic             cmp_less_i,
  input  logic             cmp_eq_i,
  input  logic             cmp_greater_i,
  output logic             res_valid_o,
  output logic             res_less_o,
  output logic             res_eq_o,
  output logic             res_greater_o
);

  localparam int CW = cnt_width(WIDTH);

  ser_state_t    state_q;
  ser_state_t    state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          load;
  logic          shift;
  logic          msb_a;
  logic          msb_b;
  logic          res_valid_q;
  logic [2:0]    res_q;

  msb_first_shift_reg #(.WIDTH(WIDTH)) u_shift_a (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (in_a_i),
    .msb_o   (msb_a)
  );

  msb_first_shift_reg #(.WIDTH(WIDTH)) u_shift_b (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (in_b_i),
    .msb_o   (msb_b)
  );

  // Next-state logic. IDLE is the only state that listens to in_valid_i.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          load    = 1'b1;
          cnt_d   = CW'(WIDTH - 1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_RESULT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESULT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // By the RESULT cycle the comparator has absorbed every bit pair, so its
  // outputs are sampled on the edge leaving RESULT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_q       <= C_RES_RESET;
    end else begin
      res_valid_q <= (state_q == ST_RESULT);
      if (state_q == ST_RESULT) begin
        res_q <= {cmp_less_i, cmp_eq_i, cmp_greater_i};
      end
    end
  end

  // Pure state decodes: cmp_clear drops in the cycle the MSB appears, and
  // zeroed serial bits outside SHIFT make the comparator hold its verdict.
  assign in_ready_o    = (state_q == ST_IDLE);
  assign cmp_clear_o   = (state_q == ST_IDLE);
  assign ser_valid_o   = (state_q == ST_SHIFT);
  assign ser_last_o    = (state_q == ST_SHIFT) && (cnt_q == '0);
  assign ser_a_o       = ser_valid_o & msb_a;
  assign ser_b_o       = ser_valid_o & msb_b;
  assign res_valid_o   = res_valid_q;
  assign res_less_o    = res_q[2];
  assign res_eq_o      = res_q[1];
  assign res_greater_o = res_q[0];

endmodule
`default_nettype wire
